// File: rtl/priority_encoder_8to3.sv
// Sequential 8-to-3 priority encoder: buffers request lines in a sticky pending set
// and issues each pending request once as a binary index over valid/ready.
module priority_encoder_8to3 #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] req,
  input  logic       ready,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pending,
  output logic       overflow
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [7:0] pend_q, pend_d;
  logic       ovf_q, ovf_d;

  logic       take;
  logic [7:0] pend_clr;
  logic [7:0] req_in;

  // Index of the highest-priority set bit; the later match in the scan wins.
  function automatic logic [2:0] enc(input logic [7:0] x);
    logic [2:0] r;
    r = 3'd0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 8; i++) if (x[i]) r = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--) if (x[i]) r = 3'(i);
    end
    return r;
  endfunction

  assign take     = (state_q == OFFER) & ready;
  assign pend_clr = pend_q & ~(take ? (8'b0000_0001 << code_q) : 8'h00);
  assign req_in   = enable ? req : 8'h00;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    code_d  = code_q;
    pend_d  = pend_clr | req_in;
    ovf_d   = |(req_in & pend_clr);
    case (state_q)
      IDLE: begin
        if (|pend_clr) begin
          state_d = OFFER;
          code_d  = enc(pend_clr);
        end
      end
      OFFER: begin
        // A stalled offer is never preempted; only an accept moves it on.
        if (ready) begin
          if (|pend_clr) code_d  = enc(pend_clr);
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= 3'd0;
      pend_q  <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign code     = code_q;
  assign valid    = (state_q == OFFER);
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Self-checking bench: two encoders (high-first and low-first) against a rank-order
// reference model, plus directed vectors with hand-computed expectations.
module tb_priority_encoder_8to3;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] req;
  logic       ready;

  logic [2:0] d_code[2];
  logic       d_valid[2];
  logic [7:0] d_pend[2];
  logic       d_ovf[2];

  int total = 0;
  int bad   = 0;

  priority_encoder_8to3 #(.HIGH_FIRST(1'b1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .ready(ready),
    .code(d_code[0]), .valid(d_valid[0]), .pending(d_pend[0]), .overflow(d_ovf[0])
  );

  priority_encoder_8to3 #(.HIGH_FIRST(1'b0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .ready(ready),
    .code(d_code[1]), .valid(d_valid[1]), .pending(d_pend[1]), .overflow(d_ovf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending set as a plain bit vector, winner chosen by walking
  // indices in rank order (instance 0 ranks 7..0, instance 1 ranks 0..7).
  function automatic int pick(input logic [7:0] s, input int k);
    for (int n = 0; n < 8; n++) begin
      int idx;
      idx = (k == 0) ? 7 - n : n;
      if (s[idx]) return idx;
    end
    return -1;
  endfunction

  logic [7:0] m_pend[2];
  logic       m_valid[2];
  logic [2:0] m_code[2];
  logic       m_ovf[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_pend[k]  <= 8'h00;
        m_valid[k] <= 1'b0;
        m_code[k]  <= 3'd0;
        m_ovf[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin : model_step
        logic [7:0] left;
        logic       accepted;
        int         w;
        accepted = m_valid[k] && ready;
        left     = m_pend[k];
        if (accepted) left[m_code[k]] = 1'b0;
        m_ovf[k]  <= enable && ((req & left) != 8'h00);
        m_pend[k] <= left | (enable ? req : 8'h00);
        if (!m_valid[k] || accepted) begin
          w = pick(left, k);
          if (w >= 0) begin
            m_valid[k] <= 1'b1;
            m_code[k]  <= 3'(w);
          end else begin
            m_valid[k] <= 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("model_valid[%0d]", k), 32'(d_valid[k]), 32'(m_valid[k]));
      check($sformatf("model_pending[%0d]", k), 32'(d_pend[k]), 32'(m_pend[k]));
      check($sformatf("model_overflow[%0d]", k), 32'(d_ovf[k]), 32'(m_ovf[k]));
      if (m_valid[k]) check($sformatf("model_code[%0d]", k), 32'(d_code[k]), 32'(m_code[k]));
    end
  end

  // Apply one cycle of inputs, return at the following falling edge.
  task automatic cyc(input logic en, input logic [7:0] r, input logic rdy);
    enable = en;
    req    = r;
    ready  = rdy;
    @(negedge clk);
  endtask

  typedef struct {
    logic       en;
    logic [7:0] r;
    logic       rdy;
  } vec_t;

  vec_t mix[14] = '{
    '{1'b1, 8'h5A, 1'b0}, '{1'b0, 8'hFF, 1'b0}, '{1'b0, 8'h00, 1'b1},
    '{1'b1, 8'h02, 1'b1}, '{1'b1, 8'h40, 1'b0}, '{1'b1, 8'h40, 1'b1},
    '{1'b0, 8'h81, 1'b1}, '{1'b1, 8'h24, 1'b1}, '{1'b1, 8'h24, 1'b0},
    '{1'b1, 8'h00, 1'b1}, '{1'b1, 8'h99, 1'b1}, '{1'b0, 8'h00, 1'b1},
    '{1'b0, 8'h00, 1'b1}, '{1'b0, 8'h00, 1'b1}
  };

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    req    = 8'h00;
    ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pending", 32'(d_pend[0]), 32'h00);
    check("rst_valid", 32'(d_valid[0]), 32'h0);
    check("rst_code", 32'(d_code[0]), 32'h0);
    check("rst_overflow", 32'(d_ovf[0]), 32'h0);
    rst_n = 1'b1;

    // Single request
    cyc(1'b1, 8'h04, 1'b1);
    check("t1_pend_e1", 32'(d_pend[0]), 32'h04);
    check("t1_valid_e1", 32'(d_valid[0]), 32'h0);
    cyc(1'b1, 8'h00, 1'b1);
    check("t1_valid_e2", 32'(d_valid[0]), 32'h1);
    check("t1_code_e2", 32'(d_code[0]), 32'h2);
    cyc(1'b1, 8'h00, 1'b1);
    check("t1_valid_e3", 32'(d_valid[0]), 32'h0);
    check("t1_pend_e3", 32'(d_pend[0]), 32'h00);

    // Priority order, both rankings
    cyc(1'b1, 8'h81, 1'b1);
    check("t2_valid_cap", 32'(d_valid[0]), 32'h0);
    cyc(1'b1, 8'h00, 1'b1);
    check("t2_hi_first", 32'(d_code[0]), 32'h7);
    check("t2_lo_first", 32'(d_code[1]), 32'h0);
    cyc(1'b1, 8'h00, 1'b1);
    check("t2_hi_second", 32'(d_code[0]), 32'h0);
    check("t2_lo_second", 32'(d_code[1]), 32'h7);
    check("t2_valid_second", 32'(d_valid[0]), 32'h1);
    cyc(1'b1, 8'h00, 1'b1);
    check("t2_valid_end", 32'(d_valid[0]), 32'h0);

    // Backpressure without preemption
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h80, 1'b0);
    check("t3_code_offer", 32'(d_code[0]), 32'h0);
    check("t3_pend", 32'(d_pend[0]), 32'h81);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'h00, 1'b0);
      check("t3_code_stall", 32'(d_code[0]), 32'h0);
      check("t3_valid_stall", 32'(d_valid[0]), 32'h1);
    end
    cyc(1'b1, 8'h00, 1'b1);
    check("t3_code_next", 32'(d_code[0]), 32'h7);
    cyc(1'b1, 8'h00, 1'b1);
    check("t3_valid_end", 32'(d_valid[0]), 32'h0);

    // Overflow on re-request of an offered, untaken index
    cyc(1'b1, 8'h10, 1'b0);
    check("t4_ovf_first", 32'(d_ovf[0]), 32'h0);
    cyc(1'b1, 8'h00, 1'b0);
    check("t4_code", 32'(d_code[0]), 32'h4);
    cyc(1'b1, 8'h10, 1'b0);
    check("t4_ovf_pulse", 32'(d_ovf[0]), 32'h1);
    check("t4_pend", 32'(d_pend[0]), 32'h10);
    cyc(1'b1, 8'h00, 1'b0);
    check("t4_ovf_drop", 32'(d_ovf[0]), 32'h0);
    cyc(1'b1, 8'h00, 1'b1);
    check("t4_valid_once", 32'(d_valid[0]), 32'h0);
    check("t4_pend_empty", 32'(d_pend[0]), 32'h00);

    // Enable low ignores requests
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'hFF, 1'b1);
      check("t5_pend_disabled", 32'(d_pend[0]), 32'h00);
      check("t5_valid_disabled", 32'(d_valid[0]), 32'h0);
    end

    // Asynchronous reset mid-cycle with a full pending set and a live offer
    cyc(1'b1, 8'hFF, 1'b0);
    cyc(1'b1, 8'h00, 1'b0);
    check("t5_pend_full", 32'(d_pend[0]), 32'hFF);
    check("t5_valid_live", 32'(d_valid[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("t5_async_pend", 32'(d_pend[k]), 32'h00);
      check("t5_async_valid", 32'(d_valid[k]), 32'h0);
      check("t5_async_code", 32'(d_code[k]), 32'h0);
      check("t5_async_ovf", 32'(d_ovf[k]), 32'h0);
    end
    enable = 1'b0;
    req    = 8'h00;
    ready  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // All eight pending drain in rank order on consecutive takes
    cyc(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'h00, 1'b1);
      check("t7_drain_valid", 32'(d_valid[0]), 32'h1);
      check("t7_drain_hi", 32'(d_code[0]), 32'(7 - i));
      check("t7_drain_lo", 32'(d_code[1]), 32'(i));
    end
    cyc(1'b1, 8'h00, 1'b1);
    check("t7_drain_done", 32'(d_valid[0]), 32'h0);

    // Same-edge re-request of the index being taken
    cyc(1'b1, 8'h08, 1'b1);
    cyc(1'b1, 8'h00, 1'b1);
    check("t6_code", 32'(d_code[0]), 32'h3);
    cyc(1'b1, 8'h08, 1'b1);
    check("t6_no_ovf", 32'(d_ovf[0]), 32'h0);
    check("t6_pend_reset", 32'(d_pend[0]), 32'h08);
    cyc(1'b1, 8'h00, 1'b1);
    check("t6_reissue_valid", 32'(d_valid[0]), 32'h1);
    check("t6_reissue_code", 32'(d_code[0]), 32'h3);
    cyc(1'b1, 8'h00, 1'b1);
    check("t6_end", 32'(d_valid[0]), 32'h0);

    // Mixed traffic checked only against the model
    foreach (mix[i]) cyc(mix[i].en, mix[i].r, mix[i].rdy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
